// File: rtl/decouple_sequencer.sv
// decouple_sequencer: drains, decouples and releases one reconfigurable region.
// Optional drain timeout is enabled with `define DECOUPLE_TIMEOUT_EN.
`default_nettype none

module decouple_sequencer #(
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 decouple_req,
    input  logic                 txn_start,
    input  logic                 txn_done,
    input  logic                 decouple_ack,
    output logic                 decouple_out,
    output logic                 block_new,
    output logic                 decoupled,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAIN     = 3'd1,
        S_ACK_WAIT  = 3'd2,
        S_DECOUPLED = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_WIDTH-1:0]   r_outstanding;
    logic                   r_decouple_out;
    logic                   r_block_new;
    logic                   r_decoupled;
    logic                   r_busy;
    logic                   w_inc;
    logic                   w_dec;
    logic                   w_drained;
    logic                   w_force;

    // Simultaneous start/done cancels; saturate high and floor at zero.
    assign w_inc = txn_start & ~txn_done & ~(&r_outstanding);
    assign w_dec = txn_done & ~txn_start & (|r_outstanding);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_outstanding <= '0;
        end else if (w_inc) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (w_dec) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    assign w_drained = (r_outstanding == '0) && !txn_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (decouple_req) w_next = S_DRAIN;
            S_DRAIN: begin
                if (!decouple_req)  w_next = S_IDLE;
                else if (w_drained) w_next = S_ACK_WAIT;
                else if (w_force)   w_next = S_ACK_WAIT;
            end
            S_ACK_WAIT:  if (decouple_ack)  w_next = S_DECOUPLED;
            S_DECOUPLED: if (!decouple_req) w_next = S_RELEASE;
            S_RELEASE:   if (!decouple_ack) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= S_IDLE;
            r_decouple_out <= 1'b0;
            r_block_new    <= 1'b0;
            r_decoupled    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_decouple_out <= (w_next == S_ACK_WAIT) || (w_next == S_DECOUPLED);
            r_block_new    <= (w_next != S_IDLE);
            r_decoupled    <= (w_next == S_DECOUPLED);
            r_busy         <= (w_next == S_DRAIN) || (w_next == S_ACK_WAIT) ||
                              (w_next == S_RELEASE);
        end
    end

`ifdef DECOUPLE_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_drain_cnt;
    logic            r_timeout_flag;

    assign w_force = (r_state == S_DRAIN) && (r_drain_cnt == c_TO_LAST);

    // Held at zero outside DRAIN, so every DRAIN entry starts from a cleared count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_drain_cnt    <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
            else                    r_drain_cnt <= '0;

            if ((r_state == S_IDLE) && (w_next == S_DRAIN))
                r_timeout_flag <= 1'b0;
            else if ((r_state == S_DRAIN) && (w_next == S_ACK_WAIT) && !w_drained)
                r_timeout_flag <= 1'b1;
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
    assign w_force              = 1'b0;
    assign timeout_flag         = 1'b0;
`endif

    assign decouple_out = r_decouple_out;
    assign block_new    = r_block_new;
    assign decoupled    = r_decoupled;
    assign busy         = r_busy;
    assign outstanding  = r_outstanding;

endmodule

`default_nettype wire
